// File: rtl/cr_structs.sv
// ============================================================================
// Module      : cr_structs
// Description : Shared AXI4-stream bus types and TLV framing definitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cr_structs;

    localparam int TLVP_TUSER_SOT = 0;
    localparam int TLVP_TUSER_EOT = 1;

    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic [3:0]  tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

    typedef enum logic [0:0] {
        CHK_IDLE   = 1'b0,
        CHK_IN_TLV = 1'b1
    } tlvp_axi_in_chk_e;

    // tvalid is the MSB of the bus struct; everything below it is the stored payload.
    localparam int AXI4S_DP_PAYLOAD_W = $bits(axi4s_dp_bus_t) - 1;

endpackage : cr_structs

`default_nettype wire

// File: rtl/cr_tlvp_axi_in_fifo.sv
// ============================================================================
// Module      : cr_tlvp_axi_in_fifo
// Description : First-word-fall-through FIFO with registered empty/aempty
//               flags and a combinational almost-full look-ahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_tlvp_axi_in_fifo #(
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_VAL  = 3,
    parameter int N_AEMPTY_VAL = 1,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              aempty,
    output logic              afull_next
);

    localparam int              c_ptr_w      = $clog2(N_ENTRIES);
    localparam int              c_cnt_w      = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(N_ENTRIES);
    localparam logic [c_cnt_w-1:0] c_afull    = c_cnt_w'(N_ENTRIES - N_AFULL_VAL);
    localparam logic [c_cnt_w-1:0] c_aempty   = c_cnt_w'(N_AEMPTY_VAL);

    logic [DATA_W-1:0]  r_mem [N_ENTRIES];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               r_empty;
    logic               r_aempty;
    logic               w_push;
    logic               w_pop;

    // A full FIFO refuses the write rather than corrupting the head entry.
    assign w_push = wen && (r_count != c_full);
    assign w_pop  = ren && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    assign afull_next = (w_count_next >= c_afull);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_aempty <= (w_count_next <= c_aempty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty  = r_empty;
    assign aempty = r_aempty;

endmodule : cr_tlvp_axi_in_fifo

`default_nettype wire

// File: rtl/cr_tlvp_axi_in_slv.sv
// ============================================================================
// Module      : cr_tlvp_axi_in_slv
// Description : AXI4-stream slave ingress buffering beats for the TLV parser.
//               Define CR_TLVP_AXI_IN_PROTO_CHK_EN to build the framing checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_tlvp_axi_in_slv
    import cr_structs::*;
#(
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_VAL  = 3,
    parameter int N_AEMPTY_VAL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t axi4s_ib_in,
    output axi4s_dp_rdy_t axi4s_ib_out,
    input  logic          tlvp_out_rd,
    output logic          tlvp_out_empty,
    output logic          tlvp_out_aempty,
    output axi4s_dp_bus_t tlvp_out_data,
    output logic          proto_error
);

    logic                          r_tready;
    logic                          w_push;
    logic                          w_afull_next;
    logic [AXI4S_DP_PAYLOAD_W-1:0] w_wdata;
    logic [AXI4S_DP_PAYLOAD_W-1:0] w_rdata;

    assign w_push  = axi4s_ib_in.tvalid && r_tready;
    assign w_wdata = axi4s_ib_in[AXI4S_DP_PAYLOAD_W-1:0];

    cr_tlvp_axi_in_fifo #(
        .N_ENTRIES    (N_ENTRIES),
        .N_AFULL_VAL  (N_AFULL_VAL),
        .N_AEMPTY_VAL (N_AEMPTY_VAL),
        .DATA_W       (AXI4S_DP_PAYLOAD_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (w_push),
        .wdata      (w_wdata),
        .ren        (tlvp_out_rd),
        .rdata      (w_rdata),
        .empty      (tlvp_out_empty),
        .aempty     (tlvp_out_aempty),
        .afull_next (w_afull_next)
    );

    // Registered tready lags one cycle; the afull margin covers the extra beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= !w_afull_next;
        end
    end

    assign axi4s_ib_out.tready = r_tready;
    assign tlvp_out_data       = {!tlvp_out_empty, w_rdata};

`ifdef CR_TLVP_AXI_IN_PROTO_CHK_EN
    tlvp_axi_in_chk_e r_chk_state;
    logic             r_proto_error;
    logic             w_sot;
    logic             w_eot;

    assign w_sot = axi4s_ib_in.tuser[TLVP_TUSER_SOT];
    assign w_eot = axi4s_ib_in.tuser[TLVP_TUSER_EOT];

    // Observes accepted beats only; violations are flagged, never back-pressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_state   <= CHK_IDLE;
            r_proto_error <= 1'b0;
        end else if (w_push) begin
            if (axi4s_ib_in.tlast && !w_eot) begin
                r_proto_error <= 1'b1;
            end
            case (r_chk_state)
                CHK_IDLE: begin
                    if (!w_sot) begin
                        r_proto_error <= 1'b1;
                    end else if (!w_eot) begin
                        r_chk_state <= CHK_IN_TLV;
                    end
                end
                CHK_IN_TLV: begin
                    if (w_sot) begin
                        r_proto_error <= 1'b1;
                    end
                    if (w_eot) begin
                        r_chk_state <= CHK_IDLE;
                    end
                end
                default: r_chk_state <= CHK_IDLE;
            endcase
        end
    end

    assign proto_error = r_proto_error;
`else
    assign proto_error = 1'b0;
`endif

endmodule : cr_tlvp_axi_in_slv

`default_nettype wire
